// File: rtl/hazard_if.sv
// hazard_if: ID-stage / ID-EX hazard signals between the pipeline and the hazard controller.
interface hazard_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_jump;
    logic       id_md_start;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       md_busy;
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_md_start,
               ex_mem_read, ex_rt, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_flush, md_busy
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_md_start,
               ex_mem_read, ex_rt, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_flush, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / mul-div hazard control for PC, IF/ID and ID/EX.
// Optional HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W   = 32
`endif
) (
    input logic clk,
    input logic reset,
    hazard_if.slave h
`ifdef HAZARD_PERF_EN
    , output logic [PERF_W-1:0] stall_cnt
    , output logic [PERF_W-1:0] flush_cnt
`endif
);
    typedef enum logic {RUN, MD_WAIT} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic load_use;
    assign load_use = h.ex_mem_read && h.ex_rt != 5'd0 &&
                      ((h.id_uses_rs && h.id_rs == h.ex_rt) || (h.id_uses_rt && h.id_rt == h.ex_rt));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        h.pc_write   = 1'b1;
        h.ifid_write = 1'b1;
        h.ifid_flush = 1'b0;
        h.idex_flush = 1'b0;
        h.md_busy    = 1'b0;
        if (h.ex_branch_taken) begin
            h.ifid_flush = 1'b1;
            h.idex_flush = 1'b1;
            state_n      = RUN;
            cnt_n        = '0;
        end else if (state == MD_WAIT) begin
            h.pc_write   = 1'b0;
            h.ifid_write = 1'b0;
            h.idex_flush = 1'b1;
            h.md_busy    = 1'b1;
            cnt_n        = cnt == '0 ? '0 : cnt - CNT_W'(1);
            state_n      = cnt == '0 ? RUN : MD_WAIT;
        end else if (load_use) begin
            h.pc_write   = 1'b0;
            h.ifid_write = 1'b0;
            h.idex_flush = 1'b1;
        end else if (h.id_md_start) begin
            // issue cycle: the mul/div proceeds into EX, ID holds from here on
            h.pc_write   = 1'b0;
            h.ifid_write = 1'b0;
            state_n      = MD_WAIT;
            cnt_n        = CNT_W'(MD_LATENCY - 2);
        end else if (h.id_jump) begin
            h.ifid_flush = 1'b1;
        end
    end
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + PERF_W'(!h.pc_write);
            flush_cnt <= flush_cnt + PERF_W'(h.ifid_flush || h.idex_flush);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven cycle vectors plus reset and perf-counter sequences.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    hazard_if hif();
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .h(hif)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
        , .flush_cnt(flush_cnt)
`endif
    );
    always #5 clk = ~clk;
    // exp = {pc_write, ifid_write, ifid_flush, idex_flush, md_busy}
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jmp;
        logic       md;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic [4:0] exp;
    } vec_t;
    vec_t vq[$];
    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic jmp, input logic md, input logic mr, input logic [4:0] ert,
                       input logic br, input logic [4:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jmp = jmp; v.md = md;
        v.mr = mr; v.ert = ert; v.br = br; v.exp = exp;
        vq.push_back(v);
    endtask
    task automatic drive(input vec_t v);
        hif.id_rs = v.rs; hif.id_rt = v.rt; hif.id_uses_rs = v.urs; hif.id_uses_rt = v.urt;
        hif.id_jump = v.jmp; hif.id_md_start = v.md; hif.ex_mem_read = v.mr;
        hif.ex_rt = v.ert; hif.ex_branch_taken = v.br;
    endtask
    function automatic logic [4:0] outs();
        return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush, hif.md_busy};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    vec_t idle;
    initial begin
        idle = '0;
        // T2 and variants
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b11000);
        add(5'd8, 5'd0, 1, 0, 0, 0, 1, 5'd8, 0, 5'b00010);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b11000);
        add(5'd0, 5'd8, 0, 1, 0, 0, 1, 5'd8, 0, 5'b00010);
        add(5'd0, 5'd8, 0, 0, 0, 0, 1, 5'd8, 0, 5'b11000);
        add(5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0, 5'b11000);
        add(5'd8, 5'd0, 1, 0, 0, 0, 0, 5'd8, 0, 5'b11000);
        add(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 5'b11100);
        add(5'd3, 5'd0, 1, 0, 1, 0, 1, 5'd3, 0, 5'b00010);
        add(5'd3, 5'd0, 1, 0, 0, 1, 1, 5'd3, 0, 5'b00010);
        // T4: issue + 3 MD_WAIT cycles, inputs ignored while waiting
        add(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 5'b00000);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b00011);
        add(5'd4, 5'd0, 1, 0, 1, 0, 1, 5'd4, 0, 5'b00011);
        add(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 5'b00011);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b11000);
        // T5: branch aborts MD_WAIT on its 2nd cycle
        add(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 5'b00000);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b00011);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 5'b11110);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b11000);
        add(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 1, 5'b11110);
        add(5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd0, 0, 5'b00000);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 5'b11110);
        add(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'b11000);
        // T1
        drive(idle);
        #2;
        check("reset_outs", 32'(outs()), 32'(5'b11000));
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
            step();
        end
        // asynchronous reset while in MD_WAIT
        drive(idle);
        hif.id_md_start = 1'b1;
        step();
        hif.id_md_start = 1'b0;
        #1;
        check("md_wait_entered", 32'(outs()), 32'(5'b00011));
        #2 reset = 1'b1;
        #1;
        check("async_reset_md", 32'(outs()), 32'(5'b11000));
        step();
        reset = 1'b0;
        step();
        check("after_reset_run", 32'(outs()), 32'(5'b11000));
`ifdef HAZARD_PERF_EN
        // T6
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("perf_reset_stall", stall_cnt, 32'd0);
        check("perf_reset_flush", flush_cnt, 32'd0);
        drive(idle);
        hif.ex_mem_read = 1'b1; hif.ex_rt = 5'd8; hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1;
        step();
        drive(idle);
        step();
        hif.id_md_start = 1'b1;
        step();
        hif.id_md_start = 1'b0;
        repeat (3) step();
        hif.id_jump = 1'b1;
        step();
        drive(idle);
        check("perf_stall_cnt", stall_cnt, 32'd5);
        check("perf_flush_cnt", flush_cnt, 32'd5);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
